// File: rtl/vc_rr_arbiter_pkg.sv
// vc_rr_arbiter_pkg: shared constants, state type and one-hot helper for the VC round-robin arbiter.
package vc_rr_arbiter_pkg;
    localparam int DATA_WIDTH_DEF = 10;
    localparam int NUM_VC = 4;
    // Destination class occupies the top CLS_W bits of every word.
    localparam int CLS_W = 2;
    localparam int CLS_HI_OFS = 1;
    localparam int CLS_LO_OFS = 2;
    typedef enum logic {IDLE, ACTIVE} state_t;
    function automatic logic [NUM_VC-1:0] onehot4(input logic [1:0] idx);
        return NUM_VC'(1) << idx;
    endfunction
endpackage

// File: rtl/vc_rr_arbiter_pick.sv
// rr_pick4: combinational round-robin picker scanning last_grant+1 .. last_grant+4 (mod 4).
module rr_pick4
    import vc_rr_arbiter_pkg::*;
(
    input  logic [NUM_VC-1:0] eligible,
    input  logic [1:0]        last_grant,
    output logic [NUM_VC-1:0] grant,
    output logic              grant_valid,
    output logic [1:0]        grant_idx
);
    // Scan from farthest to nearest so the nearest eligible index wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx = last_grant;
        for (int k = NUM_VC; k >= 1; k--) begin
            if (eligible[last_grant + 2'(k)]) begin
                grant_valid = 1'b1;
                grant_idx = last_grant + 2'(k);
            end
        end
        grant = grant_valid ? onehot4(grant_idx) : '0;
    end
endmodule

// File: rtl/vc_rr_arbiter.sv
// vc_rr_arbiter: round-robin router from four input VC FIFOs to four output class FIFOs.
module vc_rr_arbiter
    import vc_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    input  logic [NUM_VC-1:0]     empty_in,
    input  logic [NUM_VC-1:0]     almost_full_out,
    output logic [NUM_VC-1:0]     pop,
    output logic [NUM_VC-1:0]     push,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  idle,
    output logic [15:0]           fwd_count
);
    logic [DATA_WIDTH-1:0] heads [NUM_VC];
    logic [CLS_W-1:0]      dest [NUM_VC];
    logic [NUM_VC-1:0]     eligible;
    logic [NUM_VC-1:0]     grant;
    logic                  grant_valid;
    logic [1:0]            grant_idx;
    logic [1:0]            last_grant;
    state_t                state;
    state_t                state_next;

    assign heads[0] = data_in0;
    assign heads[1] = data_in1;
    assign heads[2] = data_in2;
    assign heads[3] = data_in3;

    for (genvar i = 0; i < NUM_VC; i++) begin : g_elig
        assign dest[i] = heads[i][DATA_WIDTH-CLS_HI_OFS -: CLS_W];
        assign eligible[i] = !empty_in[i] && !almost_full_out[dest[i]];
    end

    rr_pick4 u_pick (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    // Popping while held in reset would silently drop words, so pop is gated.
    assign pop = reset ? grant : '0;
    assign idle = (state == IDLE) && (push == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = ACTIVE;
            ACTIVE:  if (!grant_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last_grant <= 2'd3;
            push <= '0;
            data_out <= '0;
            fwd_count <= '0;
        end else begin
            state <= state_next;
            push <= grant_valid ? onehot4(dest[grant_idx]) : '0;
            if (grant_valid) begin
                last_grant <= grant_idx;
                data_out <= heads[grant_idx];
                fwd_count <= fwd_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_vc_rr_arbiter.sv
// tb_vc_rr_arbiter: directed vectors with a push/data scoreboard checked by a separate monitor.
module tb_vc_rr_arbiter;
    logic        clk;
    logic        reset;
    logic [9:0]  data_in0, data_in1, data_in2, data_in3;
    logic [3:0]  empty_in, almost_full_out;
    logic [3:0]  pop, push;
    logic [9:0]  data_out;
    logic        idle;
    logic [15:0] fwd_count;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_fwd = '0;
    logic [13:0] sb [$];

    vc_rr_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .data_in0       (data_in0),
        .data_in1       (data_in1),
        .data_in2       (data_in2),
        .data_in3       (data_in3),
        .empty_in       (empty_in),
        .almost_full_out(almost_full_out),
        .pop            (pop),
        .push           (push),
        .data_out       (data_out),
        .idle           (idle),
        .fwd_count      (fwd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic monitor();
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (reset && push != 4'b0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_push actual=%b/%h required=none", push, data_out);
                end else begin
                    e = sb.pop_front();
                    if ({push, data_out} !== e) begin
                        bad++;
                        $display("FAIL push_data actual=%b/%h required=%b/%h", push, data_out, e[13:10], e[9:0]);
                    end
                end
            end
        end
    endtask

    // Called just after a rising edge; drives one cycle of inputs and checks pop.
    task automatic step(input logic [3:0] e, input logic [3:0] af, input logic [9:0] a, input logic [9:0] b,
                        input logic [9:0] c, input logic [9:0] d, input logic [3:0] xp);
        logic [9:0] h [4];
        h[0] = a; h[1] = b; h[2] = c; h[3] = d;
        empty_in = e; almost_full_out = af;
        data_in0 = a; data_in1 = b; data_in2 = c; data_in3 = d;
        @(negedge clk);
        chk("pop", {28'b0, pop}, {28'b0, xp});
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (xp[i]) begin
                sb.push_back({4'b0001 << h[i][9:8], h[i]});
                exp_fwd++;
            end
        chk("fwd_count", {16'b0, fwd_count}, {16'b0, exp_fwd});
    endtask

    initial begin
        reset = 1'b0;
        empty_in = 4'hF; almost_full_out = 4'h0;
        data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
        fork monitor(); join_none
        #12;
        chk("rst_pop", {28'b0, pop}, 0);
        chk("rst_push", {28'b0, push}, 0);
        chk("rst_data", {22'b0, data_out}, 0);
        chk("rst_idle", {31'b0, idle}, 1);
        chk("rst_fwd", {16'b0, fwd_count}, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        // All four busy: grants rotate 0,1,2,3,0
        step(4'h0, 4'h0, 10'h001, 10'h101, 10'h201, 10'h301, 4'b0001);
        step(4'h0, 4'h0, 10'h001, 10'h101, 10'h201, 10'h301, 4'b0010);
        step(4'h0, 4'h0, 10'h001, 10'h101, 10'h201, 10'h301, 4'b0100);
        step(4'h0, 4'h0, 10'h001, 10'h101, 10'h201, 10'h301, 4'b1000);
        step(4'h0, 4'h0, 10'h001, 10'h101, 10'h201, 10'h301, 4'b0001);
        step(4'hF, 4'h0, 10'h001, 10'h101, 10'h201, 10'h301, 4'b0000);
        // Class 1 blocked: only input 3 moves, then 0 and 2 resume in order
        step(4'b0010, 4'b0010, 10'h100, 10'h000, 10'h1AA, 10'h005, 4'b1000);
        step(4'b0010, 4'b0010, 10'h100, 10'h000, 10'h1AA, 10'h006, 4'b1000);
        step(4'b0010, 4'b0010, 10'h100, 10'h000, 10'h1AA, 10'h007, 4'b1000);
        step(4'b1010, 4'b0010, 10'h100, 10'h000, 10'h1AA, 10'h007, 4'b0000);
        step(4'b1010, 4'b0000, 10'h100, 10'h000, 10'h1AA, 10'h007, 4'b0001);
        step(4'b1010, 4'b0000, 10'h101, 10'h000, 10'h1AA, 10'h007, 4'b0100);
        step(4'b1010, 4'b0000, 10'h101, 10'h000, 10'h1AB, 10'h007, 4'b0001);
        step(4'hF, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 4'b0000);
        // Single input 1 streaming nine words back-to-back
        for (int k = 0; k < 9; k++)
            step(4'b1101, 4'h0, 10'h000, 10'h300 + 10'(k), 10'h000, 10'h000, 4'b0010);
        chk("busy_idle", {31'b0, idle}, 0);
        step(4'hF, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 4'b0000);
        chk("drained_idle", {31'b0, idle}, 1);
        // Counter wrap
        while (exp_fwd != 16'hFFFE)
            step(4'b1110, 4'h0, 10'h0C3, 10'h000, 10'h000, 10'h000, 4'b0001);
        chk("fwd_fffe", {16'b0, fwd_count}, 32'hFFFE);
        step(4'b1110, 4'h0, 10'h0C3, 10'h000, 10'h000, 10'h000, 4'b0001);
        chk("fwd_ffff", {16'b0, fwd_count}, 32'hFFFF);
        step(4'b1110, 4'h0, 10'h0C4, 10'h000, 10'h000, 10'h000, 4'b0001);
        chk("fwd_wrap", {16'b0, fwd_count}, 0);
        // Reset while a push is in flight
        step(4'h0, 4'h0, 10'h001, 10'h101, 10'h201, 10'h301, 4'b0010);
        #2 reset = 1'b0;
        #1;
        chk("mid_push", {28'b0, push}, 0);
        chk("mid_pop", {28'b0, pop}, 0);
        chk("mid_data", {22'b0, data_out}, 0);
        chk("mid_fwd", {16'b0, fwd_count}, 0);
        chk("mid_idle", {31'b0, idle}, 1);
        sb.delete();
        exp_fwd = '0;
        empty_in = 4'hF;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        step(4'h0, 4'h0, 10'h002, 10'h102, 10'h202, 10'h302, 4'b0001);
        step(4'h0, 4'h0, 10'h002, 10'h102, 10'h202, 10'h302, 4'b0010);
        step(4'hF, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 4'b0000);
        step(4'hF, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 4'b0000);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
